// File: rtl/video_mnist_param_ctl_if.sv
// Wishbone slave bus bundle for the MNIST parameter sequencer.
interface video_mnist_param_ctl_if #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
  logic                    s_wb_we_i;
  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
  logic                    s_wb_stb_i;
  logic                    s_wb_ack_o;

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/video_mnist_param_ctl.sv
// Parameter sequencer: software stages binarizer/CNN parameters over Wishbone,
// and they are moved to the active outputs only at a frame boundary (or on an
// idle timeout when no video is flowing).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | nothing requested; idle counter held at zero
// ST_PENDING | update requested; waiting for frame start or idle timeout
module video_mnist_param_ctl #(
  parameter int          WB_ADR_WIDTH     = 8,
  parameter int          WB_DAT_WIDTH     = 32,
  parameter int          WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
  parameter logic [31:0] CORE_ID          = 32'h527a_2f10,
  parameter logic [7:0]  INIT_PARAM_TH    = 8'd127,
  parameter logic        INIT_PARAM_INV   = 1'b0,
  parameter logic [7:0]  INIT_PARAM_BLANK = 8'd3,
  parameter logic        INIT_AUTO        = 1'b0,
  parameter int          TIMEOUT_WIDTH    = 24,
  parameter int          INDEX_WIDTH      = 8
) (
  input  logic                         reset,
  input  logic                         clk,
  video_mnist_param_ctl_if.slave       s_wb,
  input  logic                         in_frame_start,
  output logic [7:0]                   out_param_th,
  output logic                         out_param_inv,
  output logic [7:0]                   out_param_blank_num,
  output logic                         out_update
);

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS  = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INDEX   = WB_ADR_WIDTH'(8'h06);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TIMEOUT = WB_ADR_WIDTH'(8'h07);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH      = WB_ADR_WIDTH'(8'h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INV     = WB_ADR_WIDTH'(8'h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_BLANK   = WB_ADR_WIDTH'(8'h0A);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic                     req_q, req_d;
  logic                     auto_q, auto_d;
  logic [7:0]               stg_th_q, stg_th_d;
  logic                     stg_inv_q, stg_inv_d;
  logic [7:0]               stg_blank_q, stg_blank_d;
  logic [7:0]               act_th_q, act_th_d;
  logic                     act_inv_q, act_inv_d;
  logic [7:0]               act_blank_q, act_blank_d;
  logic                     update_q, update_d;

  logic [WB_SEL_WIDTH-1:0]  sel;
  logic [WB_DAT_WIDTH-1:0]  wdat;
  logic [WB_DAT_WIDTH-1:0]  rdata;
  logic                     wr;
  logic                     timeout_hit;
  logic                     apply;
  logic                     unused_wb;

  assign sel         = s_wb.s_wb_sel_i;
  assign wdat        = s_wb.s_wb_dat_i;
  assign wr          = s_wb.s_wb_stb_i & s_wb.s_wb_we_i;
  assign timeout_hit = (timeout_q != '0) && (cnt_q == timeout_q);
  assign apply       = (state_q == ST_PENDING) && (in_frame_start || timeout_hit);
  // Upper data bits and byte lanes beyond the widest register are don't-care.
  assign unused_wb   = ^{wdat, sel};

  // Register file writes plus the staging-to-active transfer on apply.
  always_comb begin
    stg_th_d    = stg_th_q;
    stg_inv_d   = stg_inv_q;
    stg_blank_d = stg_blank_q;
    timeout_d   = timeout_q;
    auto_d      = auto_q;
    // Clearing on apply comes first so a req write in the apply cycle is kept.
    req_d       = apply ? 1'b0 : req_q;
    act_th_d    = apply ? stg_th_q    : act_th_q;
    act_inv_d   = apply ? stg_inv_q   : act_inv_q;
    act_blank_d = apply ? stg_blank_q : act_blank_q;
    index_d     = apply ? index_q + 1'b1 : index_q;
    update_d    = apply;
    if (wr) begin
      case (s_wb.s_wb_adr_i)
        ADR_CONTROL: if (sel[0]) begin
          if (wdat[0]) req_d = 1'b1;
          auto_d = wdat[1];
        end
        ADR_TIMEOUT: for (int i = 0; i < TIMEOUT_WIDTH; i++) begin
          if (sel[i/8]) timeout_d[i] = wdat[i];
        end
        ADR_TH:    if (sel[0]) stg_th_d    = wdat[7:0];
        ADR_INV:   if (sel[0]) stg_inv_d   = wdat[0];
        ADR_BLANK: if (sel[0]) stg_blank_d = wdat[7:0];
        default: ;
      endcase
    end
  end

  // Next-state and idle counter; IDLE looks at the upcoming req/auto so a
  // request written this cycle is pending on the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_d || auto_d) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (apply) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (s_wb.s_wb_adr_i)
      ADR_CORE_ID: rdata = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL: rdata[1:0] = {auto_q, req_q};
      ADR_STATUS:  rdata[0] = (state_q == ST_PENDING);
      ADR_INDEX:   rdata[INDEX_WIDTH-1:0] = index_q;
      ADR_TIMEOUT: rdata[TIMEOUT_WIDTH-1:0] = timeout_q;
      ADR_TH:      rdata[7:0] = stg_th_q;
      ADR_INV:     rdata[0] = stg_inv_q;
      ADR_BLANK:   rdata[7:0] = stg_blank_q;
      default: ;
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timeout_q   <= '1;
      index_q     <= '0;
      req_q       <= 1'b0;
      auto_q      <= INIT_AUTO;
      stg_th_q    <= INIT_PARAM_TH;
      stg_inv_q   <= INIT_PARAM_INV;
      stg_blank_q <= INIT_PARAM_BLANK;
      act_th_q    <= INIT_PARAM_TH;
      act_inv_q   <= INIT_PARAM_INV;
      act_blank_q <= INIT_PARAM_BLANK;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      index_q     <= index_d;
      req_q       <= req_d;
      auto_q      <= auto_d;
      stg_th_q    <= stg_th_d;
      stg_inv_q   <= stg_inv_d;
      stg_blank_q <= stg_blank_d;
      act_th_q    <= act_th_d;
      act_inv_q   <= act_inv_d;
      act_blank_q <= act_blank_d;
      update_q    <= update_d;
    end
  end

  assign s_wb.s_wb_ack_o  = s_wb.s_wb_stb_i;
  assign s_wb.s_wb_dat_o  = rdata;
  assign out_param_th        = act_th_q;
  assign out_param_inv       = act_inv_q;
  assign out_param_blank_num = act_blank_q;
  assign out_update          = update_q;

endmodule
